// File: rtl/noun_image_loader.sv
// Streams memory words into consecutive addresses through the memory unit
// handshake, then optionally launches traversal at the image start address.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 32
`endif

module noun_image_loader #(
  parameter int unsigned ADDR_WIDTH     = `MEMORY_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = `MEMORY_DATA_WIDTH,
  parameter logic [1:0]  MEM_FUNC_WRITE = 2'b01,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  auto_run,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  mem_ready,
  output logic                  mem_execute,
  output logic [1:0]            mem_func,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  bus_request,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            error,
  output logic                  traversal_execute,
  output logic [ADDR_WIDTH-1:0] start_addr
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned SUM_W = ADDR_WIDTH + 2;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SUM_W-1:0] ADDR_SPAN = SUM_W'(1) << ADDR_WIDTH;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_FETCH, S_ISSUE, S_WAIT_MEM, S_FINISH, S_FAIL
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic                  auto_run_q, auto_run_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  first_q, first_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic [1:0]            mem_func_q, mem_func_d;
  logic                  bus_request_q, bus_request_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [1:0]            error_q, error_d;
  logic                  trav_q, trav_d;
  logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
  logic [SUM_W-1:0]      span_end_c;

  // One past the last address of the image, wide enough to see overflow
  assign span_end_c = SUM_W'(start_addr_q) + SUM_W'(rem_q);

  // Execute is gated by mem_ready so a request never lands on a busy memory
  assign mem_execute       = (state_q == S_ISSUE) && mem_ready;
  assign in_ready          = (state_q == S_FETCH);
  assign mem_func          = mem_func_q;
  assign address           = address_q;
  assign write_data        = write_data_q;
  assign bus_request       = bus_request_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;
  assign traversal_execute = trav_q;
  assign start_addr        = start_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_cnt_q    <= '0;
      rem_q         <= '0;
      auto_run_q    <= 1'b0;
      tmo_q         <= '0;
      first_q       <= 1'b0;
      address_q     <= '0;
      write_data_q  <= '0;
      mem_func_q    <= '0;
      bus_request_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= ERR_NONE;
      trav_q        <= 1'b0;
      start_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      addr_cnt_q    <= addr_cnt_d;
      rem_q         <= rem_d;
      auto_run_q    <= auto_run_d;
      tmo_q         <= tmo_d;
      first_q       <= first_d;
      address_q     <= address_d;
      write_data_q  <= write_data_d;
      mem_func_q    <= mem_func_d;
      bus_request_q <= bus_request_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      trav_q        <= trav_d;
      start_addr_q  <= start_addr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_cnt_d    = addr_cnt_q;
    rem_d         = rem_q;
    auto_run_d    = auto_run_q;
    tmo_d         = tmo_q;
    first_d       = 1'b0;
    address_d     = address_q;
    write_data_d  = write_data_q;
    mem_func_d    = mem_func_q;
    error_d       = error_q;
    start_addr_d  = start_addr_q;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          addr_cnt_d   = base_addr;
          start_addr_d = base_addr;
          rem_d        = word_count;
          auto_run_d   = auto_run;
          error_d      = ERR_NONE;
          state_d      = S_CHECK;
        end
      end
      S_CHECK: begin
        if (span_end_c > ADDR_SPAN) begin
          error_d = ERR_RANGE;
          state_d = S_FAIL;
        end else if (rem_q == '0) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (in_valid) begin
          write_data_d = in_data;
          address_d    = addr_cnt_q;
          mem_func_d   = MEM_FUNC_WRITE;
          tmo_d        = '0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (mem_ready) begin
          first_d = 1'b1;
          state_d = S_WAIT_MEM;
        end else if (tmo_q == TMO_LAST) begin
          error_d = ERR_TIMEOUT;
          state_d = S_FAIL;
        end
      end
      S_WAIT_MEM: begin
        // Ready is still high in the cycle after execute; it does not mean done
        tmo_d = tmo_q + TMO_W'(1);
        if (!first_q && mem_ready) begin
          addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
          rem_d      = rem_q - CNT_W'(1);
          state_d    = (rem_q == CNT_W'(1)) ? S_FINISH : S_FETCH;
        end else if (tmo_q == TMO_LAST) begin
          error_d = ERR_TIMEOUT;
          state_d = S_FAIL;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_FAIL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Registered outputs follow the state being entered
    busy_d        = (state_d == S_CHECK) || (state_d == S_FETCH) ||
                    (state_d == S_ISSUE) || (state_d == S_WAIT_MEM);
    bus_request_d = (state_d == S_FETCH) || (state_d == S_ISSUE) ||
                    (state_d == S_WAIT_MEM);
    done_d        = (state_d == S_FINISH);
    trav_d        = (state_d == S_FINISH) && auto_run_d;
  end

endmodule

// File: tb/tb_noun_image_loader.sv
// Directed bench for noun_image_loader: loads, range and timeout errors,
// backpressure with slow memory, and reset during a load.
`timescale 1ns/1ps

module tb_noun_image_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  word_count = '0;
  logic        auto_run = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        mem_ready;
  logic        mem_execute;
  logic [1:0]  mem_func;
  logic [7:0]  address;
  logic [15:0] write_data;
  logic        bus_request;
  logic        busy;
  logic        done;
  logic [1:0]  error;
  logic        traversal_execute;
  logic [7:0]  start_addr;

  int checks = 0;
  int errors = 0;

  // Memory model: 0 ideal, 1 ready low 5 cycles per write, 2 never ready again
  int          mode = 0;
  int          hold_cnt = 0;
  logic [15:0] tb_mem [0:255];
  logic [7:0]  la [$];
  logic [15:0] ld [$];
  logic [1:0]  lf [$];

  int          done_cnt = 0;
  int          trav_cnt = 0;
  int          trav_alone = 0;
  int          exec_viol = 0;
  int          stab_viol = 0;
  logic [7:0]  trav_addr = '0;
  bit          in_wait = 1'b0;
  logic [7:0]  exec_addr = '0;
  logic [15:0] exec_data = '0;

  noun_image_loader #(
    .ADDR_WIDTH(8), .DATA_WIDTH(16), .MEM_FUNC_WRITE(2'b01), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .base_addr(base_addr),
    .word_count(word_count), .auto_run(auto_run), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_ready(mem_ready),
    .mem_execute(mem_execute), .mem_func(mem_func), .address(address),
    .write_data(write_data), .bus_request(bus_request), .busy(busy),
    .done(done), .error(error), .traversal_execute(traversal_execute),
    .start_addr(start_addr)
  );

  always #5 clk = ~clk;

  assign mem_ready = (hold_cnt == 0);

  always @(posedge clk) begin
    if (rst || !bus_request) begin
      hold_cnt <= 0;
    end else if (mem_execute && mem_ready) begin
      hold_cnt <= (mode == 2) ? 100000 : ((mode == 1) ? 5 : 1);
      tb_mem[address] <= write_data;
      la.push_back(address);
      ld.push_back(write_data);
      lf.push_back(mem_func);
    end else if (hold_cnt > 0) begin
      hold_cnt <= hold_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (traversal_execute) begin
      trav_cnt  <= trav_cnt + 1;
      trav_addr <= start_addr;
      if (!done) trav_alone <= trav_alone + 1;
    end
    if (mem_execute && !mem_ready) exec_viol <= exec_viol + 1;
    if (mem_execute) begin
      in_wait   <= 1'b1;
      exec_addr <= address;
      exec_data <= write_data;
    end else if (in_wait) begin
      if (busy && !rst && (address !== exec_addr || write_data !== exec_data))
        stab_viol <= stab_viol + 1;
      if (in_ready || !busy) in_wait <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic start_load(input logic [7:0] b, input logic [8:0] n, input logic ar);
    @(negedge clk);
    load_start = 1'b1;
    base_addr  = b;
    word_count = n;
    auto_run   = ar;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic stream(input int n, input logic [15:0] first, input bit rnd);
    int idx;
    int cyc;
    bit pend;
    idx = 0; cyc = 0; pend = 1'b0;
    while (idx < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (pend) begin idx++; pend = 1'b0; end
      if (idx < n) begin
        in_data  = first + 16'(idx);
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        pend     = in_valid && in_ready;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL stream_accept: got %0d words, required %0d", idx, n);
    end
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy && c < 500) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    checks++;
    if (c >= 500) begin
      errors++;
      $display("FAIL %s_idle: busy=%0b after %0d cycles, required 0", name, busy, c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, mem_execute, mem_func, address, write_data, bus_request, busy,
         done, error, traversal_execute, start_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b bus_request=%0b error=%0d address=%h, required all 0",
               busy, bus_request, error, address);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    int l0, d0, t0;
    mode = 0;
    l0 = la.size(); d0 = done_cnt; t0 = trav_cnt;
    start_load(8'd1, 9'd4, 1'b1);
    stream(4, 16'h000A, 1'b0);
    wait_idle("load");
    checks++;
    if (la.size() - l0 != 4) begin
      errors++;
      $display("FAIL load_write_count: got %0d, required 4", la.size() - l0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (la[l0+i] !== 8'(1 + i) || ld[l0+i] !== 16'(16'h000A + i) || lf[l0+i] !== 2'b01) begin
          errors++;
          $display("FAIL load_write%0d: addr=%h data=%h func=%0d, required addr=%h data=%h func=1",
                   i, la[l0+i], ld[l0+i], lf[l0+i], 8'(1 + i), 16'(16'h000A + i));
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tb_mem[1+i] !== 16'(16'h000A + i)) begin
        errors++;
        $display("FAIL load_mem%0d: got %h, required %h", 1 + i, tb_mem[1+i], 16'(16'h000A + i));
      end
    end
    checks++;
    if (done_cnt - d0 != 1 || trav_cnt - t0 != 1 || trav_alone != 0) begin
      errors++;
      $display("FAIL load_pulses: done=%0d trav=%0d trav_without_done=%0d, required 1 1 0",
               done_cnt - d0, trav_cnt - t0, trav_alone);
    end
    checks++;
    if (trav_addr !== 8'd1) begin
      errors++;
      $display("FAIL load_start_addr: got %h, required 01", trav_addr);
    end
  endtask

  task automatic test_range_overflow();
    int l0, d0;
    mode = 0;
    l0 = la.size(); d0 = done_cnt;
    start_load(8'hFE, 9'd3, 1'b1);
    checks++;
    if (error !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL range_check_cycle: error=%0d busy=%0b, required 0 1", error, busy);
    end
    @(negedge clk);
    checks++;
    if (error !== 2'd1 || busy !== 1'b0 || bus_request !== 1'b0) begin
      errors++;
      $display("FAIL range_error: error=%0d busy=%0b bus_request=%0b, required 1 0 0",
               error, busy, bus_request);
    end
    @(negedge clk);
    checks++;
    if (error !== 2'd1 || la.size() != l0 || done_cnt != d0) begin
      errors++;
      $display("FAIL range_sticky: error=%0d writes=%0d done=%0d, required 1 0 0",
               error, la.size() - l0, done_cnt - d0);
    end
    // Exactly reaching the top of memory is legal
    l0 = la.size();
    start_load(8'hFE, 9'd2, 1'b0);
    stream(2, 16'h00E0, 1'b0);
    wait_idle("range_edge");
    checks++;
    if (error !== 2'd0 || la.size() - l0 != 2 || la[la.size()-1] !== 8'hFF) begin
      errors++;
      $display("FAIL range_edge: error=%0d writes=%0d, required 0 2 ending at ff",
               error, la.size() - l0);
    end
  endtask

  task automatic test_zero_count();
    int l0;
    l0 = la.size();
    start_load(8'h33, 9'd0, 1'b1);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_check_cycle: done=%0b, required 0", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || traversal_execute !== 1'b1 || start_addr !== 8'h33) begin
      errors++;
      $display("FAIL zero_autorun: done=%0b trav=%0b start_addr=%h, required 1 1 33",
               done, traversal_execute, start_addr);
    end
    start_load(8'h44, 9'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || traversal_execute !== 1'b0) begin
      errors++;
      $display("FAIL zero_no_autorun: done=%0b trav=%0b, required 1 0", done, traversal_execute);
    end
    @(negedge clk);
    checks++;
    if (la.size() != l0) begin
      errors++;
      $display("FAIL zero_no_write: writes=%0d, required 0", la.size() - l0);
    end
  endtask

  task automatic test_backpressure_slow();
    int l0, d0, t0;
    mode = 1;
    l0 = la.size(); d0 = done_cnt; t0 = trav_cnt;
    start_load(8'h10, 9'd6, 1'b0);
    // A second request while busy must be ignored
    @(negedge clk);
    load_start = 1'b1; base_addr = 8'h80; word_count = 9'd1;
    @(negedge clk);
    load_start = 1'b0;
    stream(6, 16'h1230, 1'b1);
    wait_idle("slow");
    checks++;
    if (la.size() - l0 != 6) begin
      errors++;
      $display("FAIL slow_write_count: got %0d, required 6", la.size() - l0);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (la[l0+i] !== 8'(8'h10 + i) || ld[l0+i] !== 16'(16'h1230 + i)) begin
          errors++;
          $display("FAIL slow_write%0d: addr=%h data=%h, required addr=%h data=%h",
                   i, la[l0+i], ld[l0+i], 8'(8'h10 + i), 16'(16'h1230 + i));
        end
      end
    end
    checks++;
    if (exec_viol != 0 || stab_viol != 0) begin
      errors++;
      $display("FAIL slow_protocol: exec_without_ready=%0d unstable_cycles=%0d, required 0 0",
               exec_viol, stab_viol);
    end
    checks++;
    if (done_cnt - d0 != 1 || trav_cnt - t0 != 0 || error !== 2'd0) begin
      errors++;
      $display("FAIL slow_completion: done=%0d trav=%0d error=%0d, required 1 0 0",
               done_cnt - d0, trav_cnt - t0, error);
    end
    mode = 0;
  endtask

  task automatic test_timeout();
    int d0, t0, c, n;
    mode = 2;
    d0 = done_cnt; t0 = trav_cnt;
    start_load(8'h20, 9'd2, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    c = 0;
    while (!mem_execute && c < 50) begin
      @(negedge clk);
      c++;
    end
    in_valid = 1'b0;
    checks++;
    if (c >= 50) begin
      errors++;
      $display("FAIL timeout_first_exec: no execute after %0d cycles, required one", c);
    end
    n = 0;
    while (error !== 2'd2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 16 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_error: error at cycle %0d busy=%0b, required cycle 16 busy 0", n, busy);
    end
    @(negedge clk);
    checks++;
    if (done_cnt != d0 || trav_cnt != t0 || error !== 2'd2) begin
      errors++;
      $display("FAIL timeout_no_done: done=%0d trav=%0d error=%0d, required 0 0 2",
               done_cnt - d0, trav_cnt - t0, error);
    end
    mode = 0;
    start_load(8'h30, 9'd0, 1'b0);
    checks++;
    if (error !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear: error=%0d busy=%0b, required 0 1", error, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL timeout_reload_done: done=%0b, required 1", done);
    end
  endtask

  task automatic test_reset_mid_load();
    int l0, d0, t0, c;
    mode = 1;
    l0 = la.size(); t0 = trav_cnt;
    start_load(8'h40, 9'd4, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'h5A5A;
    c = 0;
    while (la.size() - l0 < 2 && c < 200) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c >= 200) begin
      errors++;
      $display("FAIL rstmid_reach_word2: writes=%0d, required 2", la.size() - l0);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, mem_execute, mem_func, address, write_data, bus_request, busy,
         done, error, traversal_execute, start_addr} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: busy=%0b mem_execute=%0b address=%h data=%h, required all 0",
               busy, mem_execute, address, write_data);
    end
    rst = 1'b0;
    mode = 0;
    @(negedge clk);
    checks++;
    if (la.size() - l0 != 2) begin
      errors++;
      $display("FAIL rstmid_no_more_writes: writes=%0d, required 2", la.size() - l0);
    end
    l0 = la.size(); d0 = done_cnt;
    start_load(8'h50, 9'd2, 1'b0);
    stream(2, 16'h0770, 1'b0);
    wait_idle("rstmid_reload");
    checks++;
    if (la.size() - l0 != 2 || la[l0] !== 8'h50 || ld[l0] !== 16'h0770 ||
        la[l0+1] !== 8'h51 || ld[l0+1] !== 16'h0771) begin
      errors++;
      $display("FAIL rstmid_reload_writes: count=%0d, required 2 writes 50:0770 51:0771",
               la.size() - l0);
    end
    checks++;
    if (done_cnt - d0 != 1 || trav_cnt != t0 || error !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_reload_done: done=%0d trav=%0d error=%0d, required 1 0 0",
               done_cnt - d0, trav_cnt - t0, error);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_range_overflow();
    test_zero_count();
    test_backpressure_slow();
    test_timeout();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
